uart_tx_ctrl: RTL

Memory-mapped UART transmit controller for the SOC IO bus; sequences bytes written by the CPU onto the TXD pin.
- Buffers CPU writes in a small FIFO, then serialises them as 8N1 frames at a fixed baud.
- Exposes status (busy, full, empty, level) so firmware can poll instead of bit-banging.
- Sits between the IO-bus address decoder and the top-level TXD pad.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 73 +++++++
 rtl/uart_tx_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
// The PARITY state is only sequenced when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter; dout shows the head entry
// combinationally so it is valid in the same cycle as pop.
import uart_pkg::*;

module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    generate
        if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    // Acceptance uses the registered level, so a write while full is lost
    // even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: FIFO-buffered CPU writes sent as 8N1 frames.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
import uart_pkg::*;

module uart_tx_ctrl #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    input  logic                          tx_enable,
    output logic                          busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          TXD,
    output uart_state_t                   dbg_state
);

    localparam int CLKS_PER_BIT       = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int CW                 = $clog2(CLKS_PER_BIT);
    localparam int BW                 = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_ctrl: CLK_FREQ_HZ / BAUD must be at least 2");
        end
    endgenerate

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          pop, bit_end, start_ok;
    logic [7:0]    fifo_dout;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESETN),
        .push  (wr_valid),
        .din   (wr_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
    assign par_d = pop ? ^fifo_dout : par_q;
`endif

    assign bit_end  = (cnt_q == CNT_LAST);
    assign start_ok = tx_enable && !fifo_empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        // Every transition happens on a bit boundary, so wrapping here also
        // clears the counter on each state change.
        if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (start_ok) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when work is queued.
                    if (start_ok) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign TXD       = txd_q;
    assign wr_ready  = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign dbg_state = state_q;

endmodule
